mux8lut_cfg_sequencer: RTL and testbench

- Configuration controller for a column of NUM_MUX wide-mux LUT slices. Each slice takes a 2-bit mode field {c1,c0}.
- A host writes mode words into a shadow register bank, then issues a commit.
- On commit the block holds downstream logic quiet, swaps shadow into active config atomically, and releases.
- Sits between the fabric config interface (or a soft CPU) and the per-slice ConfigBits inputs.

---
 rtl/mux8lut_cfg_sequencer.sv | 139 +++++++++++++
 tb/tb_mux8lut_cfg_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux8lut_cfg_sequencer.sv
// Shadow/active configuration sequencer for a column of wide-mux LUT slices.
// Optional readback port enabled by defining MUX8LUT_CFG_READBACK_EN.
module mux8lut_cfg_sequencer #(
    parameter int NUM_MUX     = 8,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int ADDR_W      = 2
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 commit_valid,
    output logic                 commit_ready,
    output logic                 commit_done,
    output logic                 cfg_hold,
    output logic                 cfg_err,
`ifdef MUX8LUT_CFG_READBACK_EN
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic                 rd_sel,
    output logic [DATA_W-1:0]    rd_data,
`endif
    output logic [2*NUM_MUX-1:0] ConfigBits
);

    localparam int         WORDS     = 2 * NUM_MUX / DATA_W;
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_HOLD,
        ST_SWAP,
        ST_POST_HOLD,
        ST_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [2*NUM_MUX-1:0] shadow_q, shadow_d;
    logic [2*NUM_MUX-1:0] config_q, config_d;
    logic                 err_q, err_d;
    logic                 wr_fire, commit_fire, wr_in_range;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed by the combinational processes.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            shadow_q <= '0;
            config_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            config_q <= config_d;
            err_q    <= err_d;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (commit_valid) begin
                    state_d = ST_PRE_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_PRE_HOLD: begin
                if (cnt_q == 4'd0) state_d = ST_SWAP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_SWAP: begin
                state_d = ST_POST_HOLD;
                cnt_d   = HOLD_LOAD;
            end
            ST_POST_HOLD: begin
                if (cnt_q == 4'd0) state_d = ST_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ready     = (state_q == ST_IDLE);
        commit_ready = (state_q == ST_IDLE);
        cfg_hold     = (state_q == ST_PRE_HOLD) || (state_q == ST_SWAP) ||
                       (state_q == ST_POST_HOLD);
        commit_done  = (state_q == ST_DONE);
    end

    // Shadow bank, error flag and the single-edge active swap.
    always_comb begin
        wr_fire     = wr_valid && wr_ready;
        commit_fire = commit_valid && commit_ready;
        wr_in_range = int'(wr_addr) < WORDS;

        shadow_d = shadow_q;
        if (wr_fire && wr_in_range)
            shadow_d[int'(wr_addr)*DATA_W +: DATA_W] = wr_data;

        // A commit in the same cycle as a bad write still clears the flag.
        err_d = err_q;
        if (commit_fire)                   err_d = 1'b0;
        else if (wr_fire && !wr_in_range)  err_d = 1'b1;

        config_d = (state_q == ST_SWAP) ? shadow_q : config_q;
    end

    assign cfg_err    = err_q;
    assign ConfigBits = config_q;

`ifdef MUX8LUT_CFG_READBACK_EN
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        if (int'(rd_addr) < WORDS)
            rd_data_d = rd_sel ? config_q[int'(rd_addr)*DATA_W +: DATA_W]
                               : shadow_q[int'(rd_addr)*DATA_W +: DATA_W];
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) rd_data_q <= '0;
        else         rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_mux8lut_cfg_sequencer.sv
// Self-checking bench for mux8lut_cfg_sequencer: directed scenarios plus random
// traffic compared cycle by cycle against a commit-timeline reference model.
module tb_mux8lut_cfg_sequencer;

    localparam int NUM_MUX = 8;
    localparam int DATA_W  = 8;
    localparam int H       = 2;
    localparam int ADDR_W  = 2;
    localparam int WORDS   = 2 * NUM_MUX / DATA_W;

    logic                 CLK = 1'b0;
    logic                 resetn;
    logic                 wr_valid, wr_ready, commit_valid, commit_ready;
    logic                 commit_done, cfg_hold, cfg_err;
    logic [ADDR_W-1:0]    wr_addr, rd_addr;
    logic [DATA_W-1:0]    wr_data, rd_data;
    logic                 rd_sel;
    logic [2*NUM_MUX-1:0] ConfigBits;

    mux8lut_cfg_sequencer #(
        .NUM_MUX(NUM_MUX), .DATA_W(DATA_W), .HOLD_CYCLES(H), .ADDR_W(ADDR_W)
    ) dut (
        .CLK(CLK), .resetn(resetn),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_done(commit_done), .cfg_hold(cfg_hold), .cfg_err(cfg_err),
`ifdef MUX8LUT_CFG_READBACK_EN
        .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
`endif
        .ConfigBits(ConfigBits)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: m_n is the position inside a commit sequence
    // (0 = idle, 1..H pre-hold, H+1 swap, H+2..2H+1 post-hold, 2H+2 done).
    logic [DATA_W-1:0]    m_shadow [WORDS];
    logic [2*NUM_MUX-1:0] m_active;
    logic                 m_err;
    logic [DATA_W-1:0]    m_rd;
    int                   m_n;

    function automatic logic [2*NUM_MUX-1:0] shadow_flat();
        logic [2*NUM_MUX-1:0] v;
        for (int w = 0; w < WORDS; w++) v[w*DATA_W +: DATA_W] = m_shadow[w];
        return v;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < WORDS; w++) m_shadow[w] = '0;
        m_active = '0;
        m_err    = 1'b0;
        m_rd     = '0;
        m_n      = 0;
    endtask

    task automatic model_step();
        if (int'(rd_addr) < WORDS)
            m_rd = rd_sel ? m_active[int'(rd_addr)*DATA_W +: DATA_W] : m_shadow[int'(rd_addr)];
        else
            m_rd = '0;
        if (m_n == 0) begin
            if (wr_valid) begin
                if (int'(wr_addr) < WORDS) m_shadow[int'(wr_addr)] = wr_data;
                else                       m_err = 1'b1;
            end
            if (commit_valid) begin
                m_err = 1'b0;
                m_n   = 1;
            end
        end else begin
            m_n++;
            if (m_n == H + 2)     m_active = shadow_flat();
            if (m_n == 2 * H + 3) m_n = 0;
        end
    endtask

    task automatic compare_all();
        check("wr_ready",     32'(wr_ready),     32'(m_n == 0));
        check("commit_ready", 32'(commit_ready), 32'(m_n == 0));
        check("cfg_hold",     32'(cfg_hold),     32'(m_n >= 1 && m_n <= 2 * H + 1));
        check("commit_done",  32'(commit_done),  32'(m_n == 2 * H + 2));
        check("cfg_err",      32'(cfg_err),      32'(m_err));
        check("ConfigBits",   32'(ConfigBits),   32'(m_active));
`ifdef MUX8LUT_CFG_READBACK_EN
        check("rd_data",      32'(rd_data),      32'(m_rd));
`endif
    endtask

    // One clock: drive, advance the model across the edge, compare after it.
    task automatic cycle(input logic wv, input int wa, input logic [DATA_W-1:0] wd,
                         input logic cv, input int ra = 0, input logic rs = 1'b0);
        wr_valid     = wv;
        wr_addr      = ADDR_W'(wa);
        wr_data      = wd;
        commit_valid = cv;
        rd_addr      = ADDR_W'(ra);
        rd_sel       = rs;
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, '0, 1'b0);
    endtask

    task automatic apply_reset();
        wr_valid = 1'b0; commit_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; rd_sel = 1'b0;
        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        compare_all();
        resetn = 1'b1;
    endtask

    initial begin
        int hold_cnt;
        int done_at;

        apply_reset();

        // Basic commit of two words, with explicit latency measurements.
        cycle(1'b1, 0, 8'hE4, 1'b0);
        cycle(1'b1, 1, 8'h1B, 1'b0);
        cycle(1'b0, 0, '0, 1'b1);
        hold_cnt = 0;
        done_at  = -1;
        for (int k = 1; k <= 2 * H + 3; k++) begin
            if (cfg_hold) hold_cnt++;
            if (commit_done && done_at < 0) done_at = k;
            if (k == 2 * H + 1) check("cfg_at_2h1", 32'(ConfigBits), 32'h1BE4);
            if (k < 2 * H + 3) cycle(1'b0, 0, '0, 1'b0);
        end
        check("hold_len", 32'(hold_cnt), 32'(2 * H + 1));
        check("done_lat", 32'(done_at), 32'(2 * H + 2));

        // Writes without commit leave the active config alone.
        cycle(1'b1, 0, 8'h12, 1'b0);
        cycle(1'b1, 1, 8'h34, 1'b0);
        cycle(1'b1, 0, 8'h56, 1'b0);
        check("no_commit_cfg", 32'(ConfigBits), 32'h1BE4);

        // Out-of-range write sets the sticky error; a commit clears it.
        cycle(1'b1, 2, 8'h99, 1'b0);
        cycle(1'b1, 3, 8'h77, 1'b0);
        check("err_sticky", 32'(cfg_err), 32'd1);
        cycle(1'b0, 0, '0, 1'b1);
        check("err_cleared", 32'(cfg_err), 32'd0);
        idle_cycles(2 * H + 2);
        check("bad_write_dropped", 32'(ConfigBits), 32'h3456);

        // Bad write and commit together: the clear wins.
        cycle(1'b1, 3, 8'hEE, 1'b1);
        check("err_clear_wins", 32'(cfg_err), 32'd0);
        idle_cycles(2 * H + 2);

        // Same-cycle write+commit, then a write held off during the sequence.
        cycle(1'b1, 0, 8'hFF, 1'b1);
        for (int k = 0; k < 2 * H + 3; k++) cycle(1'b1, 1, 8'h55, 1'b0);
        check("same_cycle_write", 32'(ConfigBits[7:0]), 32'hFF);
        check("held_write_late", 32'(ConfigBits[15:8]), 32'h34);
        cycle(1'b0, 0, '0, 1'b1);
        idle_cycles(2 * H + 2);
        check("held_write_landed", 32'(ConfigBits), 32'h55FF);

        // Reset asserted during post-hold.
        cycle(1'b1, 0, 8'hAA, 1'b0);
        cycle(1'b1, 1, 8'hAA, 1'b0);
        cycle(1'b0, 0, '0, 1'b1);
        while (m_n != H + 2) cycle(1'b0, 0, '0, 1'b0);
        check("pre_reset_cfg", 32'(ConfigBits), 32'hAAAA);
        resetn = 1'b0;
        #1;
        check("async_cfg_clear", 32'(ConfigBits), 32'h0);
        check("async_hold_clear", 32'(cfg_hold), 32'd0);
        model_reset();
        for (int k = 0; k < 2 * H + 2; k++) begin
            @(posedge CLK);
            #1;
            check("no_done_in_reset", 32'(commit_done), 32'd0);
        end
        resetn = 1'b1;
        cycle(1'b0, 0, '0, 1'b0);
        check("ready_after_reset", 32'(wr_ready), 32'd1);

`ifdef MUX8LUT_CFG_READBACK_EN
        // Readback of shadow and active words around a commit.
        cycle(1'b1, 1, 8'h3C, 1'b0, 1, 1'b0);
        check("rd_same_cycle_old", 32'(rd_data), 32'h00);
        cycle(1'b0, 0, '0, 1'b0, 1, 1'b0);
        check("rd_shadow", 32'(rd_data), 32'h3C);
        cycle(1'b0, 0, '0, 1'b1, 1, 1'b1);
        check("rd_active_old", 32'(rd_data), 32'h00);
        for (int k = 0; k < 2 * H + 2; k++) cycle(1'b0, 0, '0, 1'b0, 1, 1'b1);
        check("rd_active_new", 32'(rd_data), 32'h3C);
        cycle(1'b0, 0, '0, 1'b0, 3, 1'b0);
        check("rd_out_of_range", 32'(rd_data), 32'h00);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  DATA_W'($urandom), $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
